pipe_game_ctrl: RTL
===================

# pipe_game_ctrl

Parametrised game core for the flappy-bird design: game state machine, NUM_PIPES-deep pipe scroller, collision detection, saturating score and high score. Runs on one clock with an internal scroll-tick prescaler; it does not derive clocks from counter bits. It sits between the button/heart-rate inputs, the `bird` physics block (bird_y input) and the VGA renderer and segment display (pipe, score and state outputs).

## Interface
- NUM_PIPES, 2: simultaneous pipes (≥1)
- XW, 10 / YW, 9: x / y coordinate widths
- SCORE_W, 8: score width
- SCREEN_H, 480: playfield height
- BIRD_X, 244 / BIRD_W, 20 / BIRD_H, 27: bird box (x fixed)
- PIPE_W, 50 / PIPE_SPACING, 345 / START_X, 640: pipe width, pitch, first pipe x
- GAP_H, 140 / GAP_MIN, 40 / GAP_MAX, 300 / GAP_INIT, 100: gap height, clamp bounds, reset gap top
- TICK_DIV, 131072: clk cycles per scroll tick
- clk  in  1  system clock
- clr  in  1  synchronous reset, active-low
- jump_btn, pause_btn, restart_btn  in  1 each  level inputs, already synchronous to clk
- rate  in  2  scroll speed from heart-rate encoder
- bird_y  in  YW  bird top y, from `bird`
- rand_gap  in  YW  free-running random value
- state  out  3  game state (package enum)
- bird_run  out  1  high in PLAY only
- pipe_x  out  NUM_PIPES*XW  packed, pipe i at [i*XW +: XW]
- pipe_gap  out  NUM_PIPES*YW  packed gap-top y
- score, high_score  out  SCORE_W each
- hit  out  1  one-cycle pulse on collision

## Operation
- Buttons: registered once; act on rising edge only. Holding a button advances at most one transition.
- States: IDLE, READY, PLAY, PAUSED, LOST.
  - IDLE → READY on jump edge.
  - READY → PLAY on jump edge.
  - PLAY → PAUSED on pause edge; PAUSED → PLAY on pause edge.
  - PLAY → LOST on collision.
  - LOST → READY on restart edge.
- Entering READY (any source): pipe i x = START_X + i*PIPE_SPACING, gap = GAP_INIT, score = 0, prescaler = 0.
- Scroll step by rate:
  - 0: 0 (frozen)
  - 1: 1
  - 2: 2
  - 3: 4
- Prescaler counts in PLAY only. Tick fires on wrap at TICK_DIV-1; the prescaler holds its value in other states.
- On tick, for each pipe:
  - If x ≥ step: x ← x − step.
  - Else (respawn): x ← x + NUM_PIPES*PIPE_SPACING − step, gap ← clamp(rand_gap, GAP_MIN, GAP_MAX), score +1.
  - Score saturates at 2^SCORE_W−1. Several respawns on one tick add their count, saturating.
- Collision, evaluated in PLAY every cycle on registered values, is any of:
  - Some pipe overlaps horizontally (x < BIRD_X+BIRD_W and x+PIPE_W > BIRD_X) and bird_y < gap or bird_y+BIRD_H > gap+GAP_H.
  - bird_y == 0.
  - bird_y > SCREEN_H−BIRD_H.
- On collision: state ← LOST, hit = 1, pipes and score frozen that cycle (no tick applied). high_score ← max(high_score, score).
- Priority: collision > pause > tick. Pause edge with a tick in the same cycle: state → PAUSED and the tick is dropped.

## Timing
- All outputs registered.
- State change is visible one cycle after the input edge is registered (two cycles after the raw button rises).
- hit is asserted in the same cycle state first reads LOST.
- Pipe updates are visible the cycle after the tick.
- Reset values: state IDLE, bird_run 0, pipes at READY-entry values, score 0, high_score 0, hit 0, prescaler 0, edge registers 0.
- clr low mid-game restores all reset values, high_score included.
- Arithmetic rules: pipe x never underflows. Respawn x < NUM_PIPES*PIPE_SPACING; parameters must keep START_X+(NUM_PIPES−1)*PIPE_SPACING < 2^XW. Comparisons are done at XW+1 / YW+1 bits to avoid wrap.

## Structure
- `flappy_pkg`: state enum (IDLE=3, READY=1, PLAY=2, LOST=0, PAUSED=4) and the rate→step function.
- Sub-module `pipe_slot`: one per pipe via generate. It holds x and gap, performs step/respawn, and outputs its respawn flag and overlap/collision term.
- Top: FSM, prescaler, edge detect, score/high-score, OR-reduction of collision terms.

## Test plan
- Reset: hold clr=0 two cycles → state IDLE, pipe0 x=640 gap=100, pipe1 x=985, score 0, hit 0.
- Start: jump rising edge, held high 20 cycles → READY only. Second edge → PLAY, bird_run=1.
- Scroll: TICK_DIV=4, rate=2, bird_y=150 → pipe0 x=632 after 16 PLAY cycles. rate=0 → x unchanged over 40 cycles.
- Respawn: pipe0 x=1, rate=2, rand_gap=350 on tick → x=689, gap=300, score+1. With score=255 → score stays 255.
- Collision: pipe0 x=230, gap=100, bird_y=90 → hit pulse, state LOST, pipes frozen, high_score=score. Restart edge → READY, score 0, high_score kept.
- Priority: pause edge and collision in the same cycle → LOST, not PAUSED. Pause in PLAY → x frozen for 100 cycles, second pause resumes. clr low mid-PLAY → full reset values.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types for the flappy-bird game core: state encoding, button bundle
// and the heart-rate to scroll-step mapping.
package flappy_pkg;

  typedef enum logic [2:0] {
    LOST   = 3'd0,
    READY  = 3'd1,
    PLAY   = 3'd2,
    IDLE   = 3'd3,
    PAUSED = 3'd4
  } game_state_e;

  typedef struct packed {
    logic restart;
    logic pause;
    logic jump;
  } btn_t;

  // Faster heart rate scrolls the pipes faster; rate 0 freezes them.
  function automatic logic [2:0] rate_step(input logic [1:0] rate);
    case (rate)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One scrolling pipe: holds x and gap top, steps left on each tick and
// respawns off the right edge; reports its respawn and bird-overlap terms.
module pipe_slot
  import flappy_pkg::*;
#(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int INIT_X      = 640,
  parameter int RESPAWN_ADD = 690,
  parameter int PIPE_W      = 50,
  parameter int BIRD_X      = 244,
  parameter int BIRD_W      = 20,
  parameter int BIRD_H      = 27,
  parameter int GAP_H       = 140,
  parameter int GAP_MIN     = 40,
  parameter int GAP_MAX     = 300,
  parameter int GAP_INIT    = 100
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          tick_i,
  input  logic [2:0]    step_i,
  input  logic [YW-1:0] rand_gap_i,
  input  logic [YW-1:0] bird_y_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] gap_o,
  output logic          respawn_o,
  output logic          coll_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] gap_q, gap_d;
  logic [XW:0]   x_w, step_w;
  logic [YW:0]   y_w, gap_w, rnd_w;
  logic          respawn, h_ovl, v_out;

  assign x_w     = {1'b0, x_q};
  assign step_w  = (XW+1)'(step_i);
  assign y_w     = {1'b0, bird_y_i};
  assign gap_w   = {1'b0, gap_q};
  assign rnd_w   = {1'b0, rand_gap_i};
  assign respawn = tick_i && (x_w < step_w);

  always_comb begin
    x_d   = x_q;
    gap_d = gap_q;
    if (load_i) begin
      x_d   = XW'(INIT_X);
      gap_d = YW'(GAP_INIT);
    end else if (tick_i) begin
      if (!respawn) begin
        x_d = XW'(x_w - step_w);
      end else begin
        // Wrap by a whole pipe train so the pitch between pipes is kept.
        x_d = XW'(x_w + (XW+1)'(RESPAWN_ADD) - step_w);
        if (rnd_w < (YW+1)'(GAP_MIN))      gap_d = YW'(GAP_MIN);
        else if (rnd_w > (YW+1)'(GAP_MAX)) gap_d = YW'(GAP_MAX);
        else                               gap_d = rand_gap_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      x_q   <= XW'(INIT_X);
      gap_q <= YW'(GAP_INIT);
    end else begin
      x_q   <= x_d;
      gap_q <= gap_d;
    end
  end

  assign h_ovl = (x_w < (XW+1)'(BIRD_X + BIRD_W)) &&
                 (x_w + (XW+1)'(PIPE_W) > (XW+1)'(BIRD_X));
  assign v_out = (y_w < gap_w) ||
                 (y_w + (YW+1)'(BIRD_H) > gap_w + (YW+1)'(GAP_H));

  assign x_o       = x_q;
  assign gap_o     = gap_q;
  assign respawn_o = respawn;
  assign coll_o    = h_ovl && v_out;

endmodule

// File: rtl/pipe_game_ctrl.sv
// Flappy-bird game core: state machine, scroll prescaler, pipe scroller,
// collision detection and saturating score / high score.
module pipe_game_ctrl
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES    = 2,
  parameter int XW           = 10,
  parameter int YW           = 9,
  parameter int SCORE_W      = 8,
  parameter int SCREEN_H     = 480,
  parameter int BIRD_X       = 244,
  parameter int BIRD_W       = 20,
  parameter int BIRD_H       = 27,
  parameter int PIPE_W       = 50,
  parameter int PIPE_SPACING = 345,
  parameter int START_X      = 640,
  parameter int GAP_H        = 140,
  parameter int GAP_MIN      = 40,
  parameter int GAP_MAX      = 300,
  parameter int GAP_INIT     = 100,
  parameter int TICK_DIV     = 131072
) (
  input  logic                    clk_i,
  input  logic                    clr_i,
  input  logic                    jump_btn_i,
  input  logic                    pause_btn_i,
  input  logic                    restart_btn_i,
  input  logic [1:0]              rate_i,
  input  logic [YW-1:0]           bird_y_i,
  input  logic [YW-1:0]           rand_gap_i,
  output game_state_e             state_o,
  output logic                    bird_run_o,
  output logic [NUM_PIPES*XW-1:0] pipe_x_o,
  output logic [NUM_PIPES*YW-1:0] pipe_gap_o,
  output logic [SCORE_W-1:0]      score_o,
  output logic [SCORE_W-1:0]      high_score_o,
  output logic                    hit_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(NUM_PIPES + 1);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  game_state_e state_q, state_d;
  btn_t        btn_q, btn_d1_q, btn_edge;
  logic [PW-1:0]      presc_q, presc_d;
  logic [SCORE_W-1:0] score_q, score_d, high_q, high_d;
  logic [SCORE_W:0]   score_sum;
  logic [CW-1:0]      n_respawn;
  logic bird_run_q, bird_run_d, hit_q, hit_d;
  logic load, tick_raw, tick_apply, wall_hit, coll;
  logic [2:0] step;

  logic [NUM_PIPES-1:0][XW-1:0] pipe_x;
  logic [NUM_PIPES-1:0][YW-1:0] pipe_gap;
  logic [NUM_PIPES-1:0]         slot_resp, slot_coll;

  assign btn_edge = btn_t'(btn_q & ~btn_d1_q);
  assign step     = rate_step(rate_i);

  assign wall_hit = (bird_y_i == '0) ||
                    ({1'b0, bird_y_i} > (YW+1)'(SCREEN_H - BIRD_H));
  assign coll     = (state_q == PLAY) && (wall_hit || (|slot_coll));

  // Collision beats pause beats tick; a dropped tick still resets the prescaler.
  assign tick_raw   = (state_q == PLAY) && (presc_q == PRESC_LAST);
  assign tick_apply = tick_raw && !coll && !btn_edge.pause;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
    pipe_slot #(
      .XW(XW), .YW(YW),
      .INIT_X(START_X + i * PIPE_SPACING),
      .RESPAWN_ADD(NUM_PIPES * PIPE_SPACING),
      .PIPE_W(PIPE_W), .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
      .GAP_H(GAP_H), .GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX), .GAP_INIT(GAP_INIT)
    ) u_slot (
      .clk_i,
      .clr_i,
      .load_i    (load),
      .tick_i    (tick_apply),
      .step_i    (step),
      .rand_gap_i,
      .bird_y_i,
      .x_o       (pipe_x[i]),
      .gap_o     (pipe_gap[i]),
      .respawn_o (slot_resp[i]),
      .coll_o    (slot_coll[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (btn_edge.jump)    state_d = READY;
      READY:   if (btn_edge.jump)    state_d = PLAY;
      PLAY: begin
        if (coll)                    state_d = LOST;
        else if (btn_edge.pause)     state_d = PAUSED;
      end
      PAUSED:  if (btn_edge.pause)   state_d = PLAY;
      LOST:    if (btn_edge.restart) state_d = READY;
      default:                       state_d = IDLE;
    endcase
  end

  assign load = (state_d == READY) && (state_q != READY);

  always_comb begin
    hit_d      = coll;
    bird_run_d = (state_d == PLAY);
    presc_d    = presc_q;
    if (load)                   presc_d = '0;
    else if (state_q == PLAY)   presc_d = tick_raw ? '0 : presc_q + 1'b1;
    high_d = high_q;
    if (hit_d && (score_q > high_q)) high_d = score_q;
  end

  always_comb begin
    n_respawn = '0;
    for (int i = 0; i < NUM_PIPES; i++) n_respawn = n_respawn + CW'(slot_resp[i]);
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(n_respawn);
    score_d   = score_q;
    if (load)            score_d = '0;
    else if (tick_apply) score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX
                                                                 : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      btn_q      <= '0;
      btn_d1_q   <= '0;
      presc_q    <= '0;
      score_q    <= '0;
      high_q     <= '0;
      bird_run_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      btn_q      <= '{restart: restart_btn_i, pause: pause_btn_i, jump: jump_btn_i};
      btn_d1_q   <= btn_q;
      presc_q    <= presc_d;
      score_q    <= score_d;
      high_q     <= high_d;
      bird_run_q <= bird_run_d;
      hit_q      <= hit_d;
    end
  end

  assign state_o      = state_q;
  assign bird_run_o   = bird_run_q;
  assign pipe_x_o     = pipe_x;
  assign pipe_gap_o   = pipe_gap;
  assign score_o      = score_q;
  assign high_score_o = high_q;
  assign hit_o        = hit_q;

endmodule
